// File: rtl/mc_alu.sv
// Multi-cycle ALU: registered single-cycle logic/arith ops plus an iterative shift-add
// unsigned multiplier, with valid/ready handshakes on both request and result sides.
module mc_alu #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy
);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StMul      = 2'd1;
    localparam logic [1:0] StDoneWait = 2'd2;

    localparam logic [3:0] OpAnd   = 4'b0000;
    localparam logic [3:0] OpOr    = 4'b0001;
    localparam logic [3:0] OpAdd   = 4'b0010;
    localparam logic [3:0] OpMul   = 4'b0011;
    localparam logic [3:0] OpMulhu = 4'b0101;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpSlt   = 4'b0111;
    localparam logic [3:0] OpNor   = 4'b1100;

    localparam bit                MulEn   = (MUL_EN != 0);
    localparam int unsigned       CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0]   CntLast = CntW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               overflow_q, overflow_d;
    logic               illegal_q, illegal_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               mul_hi_q, mul_hi_d;

    logic               accept;
    logic               consume;
    logic [WIDTH-1:0]   sum, diff;
    logic               add_ovf, sub_ovf, slt_bit;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_ovf, sc_ill;
    logic               is_mul;
    logic [2*WIDTH-1:0] prod_next;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;

    assign in_ready  = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign overflow  = overflow_q;
    assign illegal   = illegal_q;
    assign busy      = (state_q == StMul);

    assign sum     = a + b;
    assign diff    = a - b;
    assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    // Sign of the difference is wrong exactly when the subtraction overflows.
    assign slt_bit = diff[WIDTH-1] ^ sub_ovf;

    always_comb begin
        sc_result = '0;
        sc_ovf    = 1'b0;
        sc_ill    = 1'b0;
        is_mul    = 1'b0;
        case (alu_ctl)
            OpAnd: sc_result = a & b;
            OpOr:  sc_result = a | b;
            OpNor: sc_result = ~(a | b);
            OpAdd: begin
                sc_result = sum;
                sc_ovf    = add_ovf;
            end
            OpSub: begin
                sc_result = diff;
                sc_ovf    = sub_ovf;
            end
            OpSlt: sc_result = {{(WIDTH-1){1'b0}}, slt_bit};
            OpMul, OpMulhu: begin
                is_mul = MulEn;
                sc_ill = !MulEn;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    assign prod_next = product_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res   = mul_hi_q ? prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];
    assign mul_ovf   = !mul_hi_q && (prod_next[2*WIDTH-1:WIDTH] != '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        product_d   = product_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        mul_hi_d    = mul_hi_q;

        if (consume) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d   = StMul;
                        product_d = '0;
                        mcand_d   = {{WIDTH{1'b0}}, a};
                        mplier_d  = b;
                        cnt_d     = '0;
                        mul_hi_d  = (alu_ctl == OpMulhu);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = sc_result;
                        zero_d      = (sc_result == '0);
                        overflow_d  = sc_ovf;
                        illegal_d   = sc_ill;
                    end
                end
            end
            StMul: begin
                product_d = prod_next;
                mcand_d   = mcand_q << 1;
                mplier_d  = mplier_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    state_d     = StDoneWait;
                    out_valid_d = 1'b1;
                    result_d    = mul_res;
                    zero_d      = (mul_res == '0);
                    overflow_d  = mul_ovf;
                    illegal_d   = 1'b0;
                    cnt_d       = '0;
                end
            end
            StDoneWait: begin
                if (consume) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            product_q   <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            mul_hi_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            product_q   <= product_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            mul_hi_q    <= mul_hi_d;
        end
    end

endmodule

// File: tb/tb_mc_alu.sv
// Directed bench for mc_alu: vector table for single-cycle ops plus hand-written
// multiply, back-pressure, MUL_EN=0 and mid-multiply reset sequences.
module tb_mc_alu;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rstn;
    logic         in_valid, out_ready;
    logic [W-1:0] a, b;
    logic [3:0]   alu_ctl;
    logic         in_ready, out_valid, zero, overflow, illegal, busy;
    logic [W-1:0] result;

    logic         in_valid2, out_ready2;
    logic         in_ready2, out_valid2, zero2, overflow2, illegal2, busy2;
    logic [W-1:0] result2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mc_alu #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_ctl(alu_ctl), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .overflow(overflow), .illegal(illegal), .busy(busy)
    );

    mc_alu #(.WIDTH(W), .MUL_EN(0)) dut_nomul (
        .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a), .b(b), .alu_ctl(alu_ctl), .out_valid(out_valid2), .out_ready(out_ready2),
        .result(result2), .zero(zero2), .overflow(overflow2), .illegal(illegal2),
        .busy(busy2)
    );

    typedef struct {
        logic [3:0]   ctl;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         ovf;
        logic         ill;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [3:0] ctl, input logic [W-1:0] res_exp,
                           input logic ovf_exp, input string tag);
        in_valid = 1'b1;
        alu_ctl  = ctl;
        a        = 32'h0001_0000;
        b        = 32'h0001_0000;
        check({tag, " in_ready before accept"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
        for (int i = 1; i <= 32; i++) begin
            if (i < 32) begin
                check({tag, " out_valid low while iterating"}, out_valid, 0);
                check({tag, " busy while iterating"}, busy, 1);
                check({tag, " in_ready low while iterating"}, in_ready, 0);
            end
            tick();
        end
        check({tag, " out_valid after 32 cycles"}, out_valid, 1);
        check({tag, " busy cleared"}, busy, 0);
        check({tag, " in_ready low in done wait"}, in_ready, 0);
        check({tag, " result"}, result, res_exp);
        check({tag, " zero"}, zero, (res_exp == '0));
        check({tag, " overflow"}, overflow, ovf_exp);
        check({tag, " illegal"}, illegal, 0);
        tick();
        check({tag, " out_valid after consume"}, out_valid, 0);
        check({tag, " in_ready back in idle"}, in_ready, 1);
    endtask

    initial begin
        vecs[0]  = '{4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 0, 1, 0};
        vecs[1]  = '{4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1, 0, 0};
        vecs[2]  = '{4'b0111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 0, 0, 0};
        vecs[3]  = '{4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0};
        vecs[4]  = '{4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 0, 0, 0};
        vecs[5]  = '{4'b1100, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 0, 0, 0};
        vecs[6]  = '{4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 0, 1, 0};
        vecs[7]  = '{4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1, 0, 0};
        vecs[8]  = '{4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0, 0};
        vecs[9]  = '{4'b1111, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 1, 0, 1};
        vecs[10] = '{4'b1000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1, 0, 1};
        vecs[11] = '{4'b0010, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 1, 0};

        rstn       = 1'b0;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        a          = '0;
        b          = '0;
        alu_ctl    = '0;
        #12;
        check("reset out_valid", out_valid, 0);
        check("reset result", result, 0);
        check("reset zero", zero, 1);
        check("reset overflow", overflow, 0);
        check("reset illegal", illegal, 0);
        check("reset busy", busy, 0);
        #4 rstn = 1'b1;
        tick();
        check("in_ready after reset", in_ready, 1);

        // Back-to-back single-cycle requests with the consumer always ready.
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            alu_ctl  = vecs[i].ctl;
            a        = vecs[i].a;
            b        = vecs[i].b;
            check($sformatf("vec%0d in_ready", i), in_ready, 1);
            tick();
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d result", i), result, vecs[i].res);
            check($sformatf("vec%0d zero", i), zero, vecs[i].z);
            check($sformatf("vec%0d overflow", i), overflow, vecs[i].ovf);
            check($sformatf("vec%0d illegal", i), illegal, vecs[i].ill);
        end
        in_valid = 1'b0;
        tick();
        check("out_valid drops after drain", out_valid, 0);

        run_mul(4'b0011, 32'h0000_0000, 1'b1, "mul");
        run_mul(4'b0101, 32'h0000_0001, 1'b0, "mulhu");

        // Back-pressure: held AND result blocks a pending ADD.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_ctl   = 4'b0000;
        a         = 32'hF0F0_F0F0;
        b         = 32'hFF00_FF00;
        tick();
        alu_ctl = 4'b0010;
        a       = 32'd2;
        b       = 32'd3;
        for (int i = 0; i < 5; i++) begin
            check("stall out_valid", out_valid, 1);
            check("stall result held", result, 32'hF000_F000);
            check("stall in_ready", in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("in_ready with out_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("consume+accept out_valid", out_valid, 1);
        check("consume+accept result", result, 32'd5);
        tick();
        check("out_valid after last consume", out_valid, 0);

        // MUL codes are illegal when the multiplier is disabled.
        for (int i = 0; i < 2; i++) begin
            in_valid2 = 1'b1;
            alu_ctl   = (i == 0) ? 4'b0011 : 4'b0101;
            a         = 32'd3;
            b         = 32'd4;
            check("nomul in_ready", in_ready2, 1);
            tick();
            in_valid2 = 1'b0;
            check("nomul out_valid", out_valid2, 1);
            check("nomul busy", busy2, 0);
            check("nomul result", result2, 0);
            check("nomul illegal", illegal2, 1);
            check("nomul zero", zero2, 1);
            check("nomul overflow", overflow2, 0);
            tick();
            check("nomul drained", out_valid2, 0);
        end

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        alu_ctl  = 4'b0011;
        a        = 32'h0001_0000;
        b        = 32'h0001_0000;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("busy before abort", busy, 1);
        rstn = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort busy", busy, 0);
        check("abort zero", zero, 1);
        #2 rstn = 1'b1;
        tick();
        check("abort in_ready", in_ready, 1);
        check("abort still no result", out_valid, 0);
        in_valid = 1'b1;
        alu_ctl  = 4'b0010;
        a        = 32'd2;
        b        = 32'd3;
        tick();
        in_valid = 1'b0;
        check("post-abort out_valid", out_valid, 1);
        check("post-abort result", result, 32'd5);
        check("post-abort overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
